// File: rtl/seq_pkg.sv
// Shared defaults, FSM state encoding and error-bit positions for the result-sequence store.
package seq_pkg;

   localparam int DEPTH_DEF = 10;
   localparam int WIDTH_DEF = 32;
   localparam int IDX_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FILL  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam int ERR_FSM = 0;
   localparam int ERR_OVF = 1;

endpackage

// File: rtl/seq_store_ctrl_if.sv
// Write channel from the conversion FSM plus display-side status of the sequence store.
interface seq_store_ctrl_if
   import seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int IDX_W = IDX_W_DEF
);
   logic             wr_valid;
   logic             wr_err;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] rd_data;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] count;
   logic             full;
   logic [1:0]       err_code;

   modport master (
      output wr_valid, wr_err, wr_data,
      input  rd_data, rd_idx, count, full, err_code
   );

   modport slave (
      input  wr_valid, wr_err, wr_data,
      output rd_data, rd_idx, count, full, err_code
   );
endinterface

// File: rtl/seq_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after we; no backpressure.
module seq_mem
   import seq_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);
   // Contents are deliberately left unreset; the controller masks reads while empty.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/seq_store_ctrl.sv
// Result-sequence store controller: write pointer, fill count, display pointer, sticky errors.
// Latency: write/nxt take effect next cycle, rd_data is combinational; writes while full are dropped.
module seq_store_ctrl
   import seq_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            nxt,
   seq_store_ctrl_if.slave bus
);
   localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic [IDX_W-1:0] count_q, count_d;
   logic [1:0]       err_q, err_d;
   logic             is_full, is_empty, mem_we;
   logic [WIDTH-1:0] mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_EMPTY;
         wr_ptr_q <= '0;
         rd_idx_q <= '0;
         count_q  <= '0;
         err_q    <= 2'b00;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_idx_q <= rd_idx_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (mem_we) state_d = (DEPTH == 1) ? ST_FULL : ST_FILL;
            ST_FILL:  if (mem_we && count_q == LAST_IDX) state_d = ST_FULL;
            ST_FULL:  state_d = ST_FULL;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      is_full  = (state_q == ST_FULL);
      is_empty = (state_q == ST_EMPTY);
      mem_we   = bus.wr_valid && !bus.wr_err && !is_full && !clear;
   end

   // The nxt wrap decision uses the pre-write count so a same-cycle write cannot extend the walk.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_idx_d = rd_idx_q;
      count_d  = count_q;
      err_d    = err_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_idx_d = '0;
         count_d  = '0;
         err_d    = 2'b00;
      end else begin
         if (mem_we) begin
            wr_ptr_d = wr_ptr_q + ONE;
            count_d  = count_q + ONE;
         end
         if (bus.wr_valid && bus.wr_err) begin
            err_d[ERR_FSM] = 1'b1;
         end
         if (bus.wr_valid && !bus.wr_err && is_full) begin
            err_d[ERR_OVF] = 1'b1;
         end
         if (nxt && !is_empty) begin
            rd_idx_d = (rd_idx_q == count_q - ONE) ? '0 : rd_idx_q + ONE;
         end
      end
   end

   seq_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr_q),
      .wdata (bus.wr_data),
      .raddr (rd_idx_q),
      .rdata (mem_rdata)
   );

   assign bus.rd_data  = (count_q != '0) ? mem_rdata : '0;
   assign bus.rd_idx   = rd_idx_q;
   assign bus.count    = count_q;
   assign bus.full     = is_full;
   assign bus.err_code = err_q;
endmodule
